// File: rtl/sram_controller_pkg.sv
// Shared types and defaults for the two-half-word SRAM access controller.
package sram_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LO   = 2'd1,
        HI   = 2'd2,
        DONE = 2'd3
    } state_e;

    localparam int          SRAM_DW             = 16;
    localparam logic [31:0] DEF_BASE_ADDR       = 32'd1024;
    localparam int          DEF_ACCESS_CYCLES   = 3;

    // 32-bit word index relative to the SRAM base; wraps modulo 2^32.
    function automatic logic [31:0] word_index(input logic [31:0] addr, input logic [31:0] base);
        logic [31:0] offset;
        offset = addr - base;
        return {2'b00, offset[31:2]};
    endfunction

endpackage

// File: rtl/sram_controller.sv
// Runs one 32-bit load/store as two 16-bit accesses on an asynchronous SRAM,
// freezing the pipeline through a combinational ready until the access completes.
module sram_controller
    import sram_ctrl_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR     = DEF_BASE_ADDR,
    parameter int          ACCESS_CYCLES = DEF_ACCESS_CYCLES,
    parameter int          SRAM_AW       = 18
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               rd_en,
    input  logic               wr_en,
    input  logic [31:0]        address,
    input  logic [31:0]        write_data,
    output logic [31:0]        read_data,
    output logic               ready,
    output logic [SRAM_AW-1:0] sram_addr,
    output logic [SRAM_DW-1:0] sram_dq_out,
    input  logic [SRAM_DW-1:0] sram_dq_in,
    output logic               sram_dq_oe,
    output logic               sram_we_n
);

    localparam logic [3:0] LAST_CNT = 4'(ACCESS_CYCLES - 1);

    state_e               state_q, state_d;
    logic [3:0]           cnt_q, cnt_d;
    logic                 op_wr_q, op_wr_d;
    logic [SRAM_AW-2:0]   word_q, word_d;
    logic [31:0]          wdata_q, wdata_d;
    logic [SRAM_DW-1:0]   lo_buf_q, lo_buf_d;
    logic [31:0]          read_data_q, read_data_d;
    logic [SRAM_AW-1:0]   sram_addr_q, sram_addr_d;
    logic [SRAM_DW-1:0]   dq_out_q, dq_out_d;
    logic                 dq_oe_q, dq_oe_d;
    logic                 we_n_q, we_n_d;

    logic                 req_s;
    logic                 last_s;
    logic [31:0]          word_idx_s;
    logic                 unused_word_s;

    assign req_s         = rd_en | wr_en;
    assign last_s        = (cnt_q == LAST_CNT);
    assign word_idx_s    = word_index(address, BASE_ADDR);
    assign unused_word_s = ^word_idx_s[31:SRAM_AW-1];

    // Next-state, latch and capture logic; SRAM pin values are derived from the next state.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        op_wr_d     = op_wr_q;
        word_d      = word_q;
        wdata_d     = wdata_q;
        lo_buf_d    = lo_buf_q;
        read_data_d = read_data_q;
        sram_addr_d = sram_addr_q;
        dq_out_d    = dq_out_q;
        dq_oe_d     = 1'b0;
        we_n_d      = 1'b1;

        case (state_q)
            IDLE: begin
                if (req_s) begin
                    state_d = LO;
                    cnt_d   = 4'd0;
                    op_wr_d = wr_en;
                    word_d  = word_idx_s[SRAM_AW-2:0];
                    wdata_d = write_data;
                end else begin
                    state_d = IDLE;
                end
            end
            LO: begin
                if (last_s) begin
                    state_d = HI;
                    cnt_d   = 4'd0;
                    if (!op_wr_q) begin
                        lo_buf_d = sram_dq_in;
                    end else begin
                        lo_buf_d = lo_buf_q;
                    end
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            HI: begin
                if (last_s) begin
                    state_d = DONE;
                    cnt_d   = 4'd0;
                    if (!op_wr_q) begin
                        read_data_d = {sram_dq_in, lo_buf_q};
                    end else begin
                        read_data_d = read_data_q;
                    end
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
                cnt_d   = 4'd0;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 4'd0;
            end
        endcase

        // Strobe releases on the last cycle of each half so address/data hold past it.
        case (state_d)
            LO: begin
                sram_addr_d = {word_d, 1'b0};
                dq_out_d    = wdata_d[15:0];
                dq_oe_d     = op_wr_d;
                we_n_d      = ~(op_wr_d && (cnt_d != LAST_CNT));
            end
            HI: begin
                sram_addr_d = {word_d, 1'b1};
                dq_out_d    = wdata_d[31:16];
                dq_oe_d     = op_wr_d;
                we_n_d      = ~(op_wr_d && (cnt_d != LAST_CNT));
            end
            default: begin
                dq_oe_d = 1'b0;
                we_n_d  = 1'b1;
            end
        endcase
    end

    // State, latched request and registered SRAM pins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            op_wr_q     <= 1'b0;
            word_q      <= '0;
            wdata_q     <= 32'd0;
            lo_buf_q    <= '0;
            read_data_q <= 32'd0;
            sram_addr_q <= '0;
            dq_out_q    <= '0;
            dq_oe_q     <= 1'b0;
            we_n_q      <= 1'b1;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            op_wr_q     <= op_wr_d;
            word_q      <= word_d;
            wdata_q     <= wdata_d;
            lo_buf_q    <= lo_buf_d;
            read_data_q <= read_data_d;
            sram_addr_q <= sram_addr_d;
            dq_out_q    <= dq_out_d;
            dq_oe_q     <= dq_oe_d;
            we_n_q      <= we_n_d;
        end
    end

    assign ready       = ((state_q == IDLE) && !req_s) || (state_q == DONE);
    assign read_data   = read_data_q;
    assign sram_addr   = sram_addr_q;
    assign sram_dq_out = dq_out_q;
    assign sram_dq_oe  = dq_oe_q;
    assign sram_we_n   = we_n_q;

endmodule

// File: tb/tb_sram_controller.sv
// Directed bench for sram_controller with a small behavioural SRAM.
module tb_sram_controller;

    logic        clk;
    logic        rst_n;
    logic        rd_en;
    logic        wr_en;
    logic [31:0] address;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        ready;
    logic [17:0] sram_addr;
    logic [15:0] sram_dq_out;
    logic [15:0] sram_dq_in;
    logic        sram_dq_oe;
    logic        sram_we_n;

    logic [15:0] mem [0:63];

    int n_cmp = 0;
    int n_bad = 0;

    logic        ready_log [8];
    logic [17:0] addr_log  [8];
    logic [15:0] dqo_log   [8];
    logic        oe_log    [8];
    logic        we_log    [8];
    logic [31:0] rdata_log [8];

    sram_controller dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rd_en       (rd_en),
        .wr_en       (wr_en),
        .address     (address),
        .write_data  (write_data),
        .read_data   (read_data),
        .ready       (ready),
        .sram_addr   (sram_addr),
        .sram_dq_out (sram_dq_out),
        .sram_dq_in  (sram_dq_in),
        .sram_dq_oe  (sram_dq_oe),
        .sram_we_n   (sram_we_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign sram_dq_in = mem[sram_addr[5:0]];

    always @(posedge clk) begin
        if (!sram_we_n && sram_dq_oe) mem[sram_addr[5:0]] <= sram_dq_out;
    end

    // Issue one request at posedge+1 and log the pins at eight negedges (cycles 0..7).
    task automatic run_access(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d);
        rd_en = rd; wr_en = wr; address = a; write_data = d;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            ready_log[k] = ready;  addr_log[k] = sram_addr; dqo_log[k] = sram_dq_out;
            oe_log[k] = sram_dq_oe; we_log[k] = sram_we_n;  rdata_log[k] = read_data;
        end
        @(posedge clk); #1;
        rd_en = 1'b0; wr_en = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; rd_en = 1'b0; wr_en = 1'b0; address = 32'd0; write_data = 32'd0;
        repeat (2) @(negedge clk);
        n_cmp++; if (ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready: got %b expected 1", ready); end
        n_cmp++; if (sram_we_n !== 1'b1) begin n_bad++; $display("FAIL reset_we_n: got %b expected 1", sram_we_n); end
        n_cmp++; if (sram_dq_oe !== 1'b0) begin n_bad++; $display("FAIL reset_oe: got %b expected 0", sram_dq_oe); end
        n_cmp++; if (sram_addr !== 18'd0) begin n_bad++; $display("FAIL reset_addr: got %h expected 0", sram_addr); end
        n_cmp++; if (sram_dq_out !== 16'd0) begin n_bad++; $display("FAIL reset_dq_out: got %h expected 0", sram_dq_out); end
        n_cmp++; if (read_data !== 32'd0) begin n_bad++; $display("FAIL reset_read_data: got %h expected 0", read_data); end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_idle;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            n_cmp++; if (ready !== 1'b1) begin n_bad++; $display("FAIL idle_ready[%0d]: got %b expected 1", k, ready); end
            n_cmp++; if (sram_we_n !== 1'b1 || sram_dq_oe !== 1'b0) begin
                n_bad++; $display("FAIL idle_pins[%0d]: got we_n=%b oe=%b expected 1/0", k, sram_we_n, sram_dq_oe); end
            n_cmp++; if (sram_addr !== 18'd0) begin n_bad++; $display("FAIL idle_addr[%0d]: got %h expected 0", k, sram_addr); end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_write;
        logic [17:0] e_addr;
        logic [15:0] e_dq;
        run_access(1'b0, 1'b1, 32'd1032, 32'hDEADBEEF);
        for (int k = 0; k < 8; k++) begin
            n_cmp++; if (ready_log[k] !== (k == 7)) begin n_bad++; $display("FAIL wr_ready[%0d]: got %b expected %b", k, ready_log[k], k == 7); end
            n_cmp++; if (we_log[k] !== (k == 0 || k == 3 || k == 6 || k == 7)) begin
                n_bad++; $display("FAIL wr_we_n[%0d]: got %b", k, we_log[k]); end
            n_cmp++; if (oe_log[k] !== (k >= 1 && k <= 6)) begin n_bad++; $display("FAIL wr_oe[%0d]: got %b", k, oe_log[k]); end
            if (k >= 1 && k <= 6) begin
                e_addr = (k <= 3) ? 18'd4 : 18'd5;
                e_dq   = (k <= 3) ? 16'hBEEF : 16'hDEAD;
                n_cmp++; if (addr_log[k] !== e_addr) begin n_bad++; $display("FAIL wr_addr[%0d]: got %h expected %h", k, addr_log[k], e_addr); end
                n_cmp++; if (dqo_log[k] !== e_dq) begin n_bad++; $display("FAIL wr_dq[%0d]: got %h expected %h", k, dqo_log[k], e_dq); end
            end
        end
        n_cmp++; if (mem[4] !== 16'hBEEF || mem[5] !== 16'hDEAD) begin
            n_bad++; $display("FAIL wr_mem: got %h_%h expected DEAD_BEEF", mem[5], mem[4]); end
        repeat (2) @(posedge clk); #1;
    endtask

    task automatic test_read;
        run_access(1'b1, 1'b0, 32'd1032, 32'h0);
        for (int k = 0; k < 8; k++) begin
            n_cmp++; if (ready_log[k] !== (k == 7)) begin n_bad++; $display("FAIL rd_ready[%0d]: got %b expected %b", k, ready_log[k], k == 7); end
            n_cmp++; if (oe_log[k] !== 1'b0 || we_log[k] !== 1'b1) begin
                n_bad++; $display("FAIL rd_pins[%0d]: got oe=%b we_n=%b expected 0/1", k, oe_log[k], we_log[k]); end
        end
        n_cmp++; if (addr_log[2] !== 18'd4 || addr_log[5] !== 18'd5) begin
            n_bad++; $display("FAIL rd_addr: got %h/%h expected 4/5", addr_log[2], addr_log[5]); end
        n_cmp++; if (rdata_log[6] !== 32'd0) begin n_bad++; $display("FAIL rd_early: got %h expected 0", rdata_log[6]); end
        n_cmp++; if (rdata_log[7] !== 32'hDEADBEEF) begin n_bad++; $display("FAIL rd_data: got %h expected deadbeef", rdata_log[7]); end
        @(negedge clk);
        n_cmp++; if (ready !== 1'b1 || read_data !== 32'hDEADBEEF) begin
            n_bad++; $display("FAIL rd_hold: got ready=%b data=%h expected 1/deadbeef", ready, read_data); end
        @(posedge clk); #1;
    endtask

    task automatic test_both;
        int lows;
        lows = 0;
        run_access(1'b1, 1'b1, 32'd1024, 32'h12345678);
        for (int k = 0; k < 8; k++) if (we_log[k] === 1'b0) lows++;
        n_cmp++; if (lows !== 4) begin n_bad++; $display("FAIL both_we_count: got %0d expected 4", lows); end
        n_cmp++; if (addr_log[1] !== 18'd0 || addr_log[4] !== 18'd1) begin
            n_bad++; $display("FAIL both_addr: got %h/%h expected 0/1", addr_log[1], addr_log[4]); end
        n_cmp++; if (rdata_log[7] !== 32'hDEADBEEF) begin n_bad++; $display("FAIL both_rdata: got %h expected deadbeef", rdata_log[7]); end
        n_cmp++; if (mem[0] !== 16'h5678 || mem[1] !== 16'h1234) begin
            n_bad++; $display("FAIL both_mem: got %h_%h expected 1234_5678", mem[1], mem[0]); end
        repeat (2) @(posedge clk); #1;
    endtask

    task automatic test_async_reset;
        rd_en = 1'b1; wr_en = 1'b0; address = 32'd1032; write_data = 32'h0;
        repeat (6) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if (read_data !== 32'd0) begin n_bad++; $display("FAIL arst_rdata: got %h expected 0", read_data); end
        n_cmp++; if (sram_addr !== 18'd0 || sram_dq_out !== 16'd0) begin
            n_bad++; $display("FAIL arst_pins: got addr=%h dq=%h expected 0/0", sram_addr, sram_dq_out); end
        n_cmp++; if (sram_dq_oe !== 1'b0 || sram_we_n !== 1'b1 || ready !== 1'b0) begin
            n_bad++; $display("FAIL arst_ctl: got oe=%b we_n=%b ready=%b expected 0/1/0", sram_dq_oe, sram_we_n, ready); end
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 1; k < 8; k++) begin
            @(negedge clk);
            n_cmp++; if (ready !== (k == 7)) begin n_bad++; $display("FAIL arst_ready[%0d]: got %b expected %b", k, ready, k == 7); end
        end
        n_cmp++; if (read_data !== 32'hDEADBEEF) begin n_bad++; $display("FAIL arst_restart: got %h expected deadbeef", read_data); end
        @(posedge clk); #1;
        rd_en = 1'b0;
        repeat (2) @(posedge clk); #1;
    endtask

    task automatic test_back_to_back;
        rd_en = 1'b0; wr_en = 1'b1; address = 32'd1024; write_data = 32'hA5A53C3C;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            n_cmp++; if (ready !== (k == 7 || k == 15)) begin
                n_bad++; $display("FAIL b2b_ready[%0d]: got %b expected %b", k, ready, (k == 7 || k == 15)); end
            if (k == 7) begin
                @(posedge clk); #1;
                rd_en = 1'b1; wr_en = 1'b0; write_data = 32'h0;
            end
        end
        n_cmp++; if (read_data !== 32'hA5A53C3C) begin n_bad++; $display("FAIL b2b_rdata: got %h expected a5a53c3c", read_data); end
        @(posedge clk); #1;
        rd_en = 1'b0;
    endtask

    initial begin
        test_reset();
        test_idle();
        test_write();
        test_read();
        test_both();
        test_async_reset();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/sram_controller.md
Name: sram_controller

Overview:
- Multi-cycle memory access controller for memory-type instructions. Takes the effective address that the execute stage computes (ALU result) plus the MEM read/write enables and runs one 32-bit access as two 16-bit half-word accesses on an external asynchronous SRAM.
- Drives a ready/freeze handshake that stalls the pipeline for the whole access.
- Sits between the EXE/MEM pipeline register and the off-chip SRAM pins.

Parameters:
- BASE_ADDR, 1024, byte address that maps to SRAM word 0.
- ACCESS_CYCLES, 3, clock cycles per 16-bit half access; legal range 2..15.
- SRAM_AW, 18, SRAM address width in half-words.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- rd_en  in  1  MEM_R_EN of the instruction in MEM; held stable while ready=0.
- wr_en  in  1  MEM_W_EN of the instruction in MEM; held stable while ready=0.
- address  in  32  byte address (ALU result); held while ready=0.
- write_data  in  32  store data (Val_Rm); held while ready=0.
- read_data  out  32  loaded word.
- ready  out  1  1 = no access pending or access completing this cycle; pipeline freeze = ~ready.
- sram_addr  out  SRAM_AW  half-word address.
- sram_dq_out  out  16  write data to the SRAM data pins.
- sram_dq_in  in  16  read data from the SRAM data pins.
- sram_dq_oe  out  1  1 = controller drives the data pins.
- sram_we_n  out  1  SRAM write strobe, active low.

Behaviour:
- Reset (async, rst_n=0), takes effect immediately and holds:
  - state=IDLE, counter=0, read_data=0.
  - sram_addr=0, sram_dq_out=0, sram_dq_oe=0, sram_we_n=1.
  - ready = combinational rule below.
- Reset mid-access aborts it. No partial read_data update. After reset, a still-asserted request restarts from IDLE.
- Address map:
  - w = (address - BASE_ADDR) >> 2, 32-bit subtraction, wraps modulo 2^32.
  - Low half-word address = {w[SRAM_AW-2:0],1'b0}; high = {w[SRAM_AW-2:0],1'b1}.
  - address[1:0] ignored.
- Request resolution: req = rd_en | wr_en. If both are 1, the access is a write.
- ready is combinational: (state==IDLE & ~req) | (state==DONE).
- States:
  - IDLE: if req, latch op, address and write_data; counter=0; go to LO. ready=0 this cycle.
  - LO: sram_addr=low address for ACCESS_CYCLES cycles, then go to HI.
  - HI: same as LO with the high address, then go to DONE.
  - DONE: one cycle, ready=1; next state IDLE unconditionally. The pipeline advances at the end of DONE; the next request is sampled in IDLE.
- Latency:
  - The request is present in cycle 0 and ready=1 in cycle 2*ACCESS_CYCLES+1.
  - Freeze lasts 2*ACCESS_CYCLES+1 cycles (7 at default).
  - Back-to-back requests cost no extra cycle beyond the IDLE sample cycle.
- Read:
  - sram_dq_oe=0, sram_we_n=1 throughout.
  - On the last LO cycle, sram_dq_in is captured into lo_buf.
  - On the last HI cycle, read_data <= {sram_dq_in, lo_buf}.
  - read_data otherwise holds, including across writes.
- Write:
  - In LO: sram_dq_out=write_data[15:0], sram_dq_oe=1.
  - In HI: sram_dq_out=write_data[31:16], sram_dq_oe=1.
  - sram_we_n=0 for the first ACCESS_CYCLES-1 cycles of each half and 1 on the last cycle, so data and address hold past the strobe.
- Outside LO/HI: sram_dq_oe=0 and sram_we_n=1.
- Counter is 4 bits and reloads to 0 on each half transition. It never wraps within a legal ACCESS_CYCLES.
- Input changes while ready=0 are a protocol violation. The latched copies keep the access coherent regardless.

Decomposition:
- Package sram_ctrl_pkg:
  - State enum (IDLE, LO, HI, DONE), 2-bit encoding.
  - SRAM data width constant (16).
  - Default BASE_ADDR/ACCESS_CYCLES constants.
- Single module; no sub-module needed. The cycle counter stays inline.

Test Plan:
- Idle: rd_en=wr_en=0 for 10 cycles -> ready=1 every cycle, sram_we_n=1, sram_dq_oe=0, sram_addr stable.
- Write: wr_en=1, address=1024+8, write_data=0xDEADBEEF ->
  - sram_addr=4 with dq_out=0xBEEF, then sram_addr=5 with dq_out=0xDEAD.
  - we_n low 2 cycles in each half.
  - ready=1 exactly at cycle 7.
- Read back: with the SRAM model holding the previous write, rd_en=1, address=1032 -> read_data=0xDEADBEEF at cycle 7, ready pulses for one cycle, oe=0 throughout.
- Simultaneous rd_en=wr_en=1, address=1024, write_data=0x12345678 -> a write is performed (we_n pulses) and read_data is unchanged.
- Async reset: assert rst_n=0 during the third cycle of HI of a read -> outputs go to reset values immediately and read_data=0. Release with rd_en held -> the full 7-cycle access restarts and completes.
- Back-to-back: a write to 1024 followed in the next IDLE by a read of 1024 -> two 7-cycle freezes with no gap cycle, and read_data equals the written word.
